// File: rtl/ysyx_25040101_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040101_wb_arbiter
// Brief    : Register-file write-port arbiter for EXU and LSU writebacks.
//            Contains a one-cycle writeback stage, a pending-load scoreboard
//            for x1..x31, an outstanding-load counter and the issue hazard.
//            Define YSYX_25040101_WB_RR_EN for round-robin arbitration.
//            Without it, arbitration is fixed priority with LSU first.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040101_wb_arbiter #(
    parameter int MAX_LD = 2,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_valid_i,
    input  logic [4:0]       exu_rd_i,
    input  logic [31:0]      exu_data_i,
    output logic             exu_ready_o,
    input  logic             lsu_valid_i,
    input  logic [4:0]       lsu_rd_i,
    input  logic [31:0]      lsu_data_i,
    output logic             lsu_ready_o,
    input  logic             ld_issue_valid_i,
    input  logic [4:0]       ld_issue_rd_i,
    output logic             ld_issue_ready_o,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       id_rd_i,
    output logic             hazard_o,
    output logic             rd_wen_o,
    output logic [4:0]       rd_addr_o,
    output logic [31:0]      rd_data_o,
    output logic [CNT_W-1:0] ld_cnt_o
);

    localparam logic [CNT_W-1:0] c_max_ld  = CNT_W'(MAX_LD);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [31:0]      r_busy;
    logic [CNT_W-1:0] r_ld_cnt;
    logic             r_wb_vld;
    logic [4:0]       r_wb_addr;
    logic [31:0]      r_wb_data;

    logic             w_lsu_req;
    logic             w_lsu_fire;
    logic             w_exu_fire;
    logic             w_ld_fire;
    logic [4:0]       w_win_rd;
    logic [31:0]      w_win_data;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_haz_waw;

    // A return with nothing in flight is a stray and is never granted.
    assign w_lsu_req = lsu_valid_i & (r_ld_cnt != '0);

`ifdef YSYX_25040101_WB_RR_EN
    // 0: EXU was granted last, 1: LSU was granted last.
    logic r_last_grant;

    assign lsu_ready_o = w_lsu_req & ~(exu_valid_i & r_last_grant);
    assign exu_ready_o = exu_valid_i & ~(w_lsu_req & ~r_last_grant);

    // Remember the most recent winner so the other side is favoured next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b0;
        end else if (w_lsu_fire) begin
            r_last_grant <= 1'b1;
        end else if (w_exu_fire) begin
            r_last_grant <= 1'b0;
        end
    end
`else
    assign lsu_ready_o = w_lsu_req;
    assign exu_ready_o = exu_valid_i & ~w_lsu_req;
`endif

    assign w_lsu_fire = lsu_valid_i & lsu_ready_o;
    assign w_exu_fire = exu_valid_i & exu_ready_o;

    // Registered busy only: a register can never be set and cleared together.
    assign ld_issue_ready_o = (r_ld_cnt < c_max_ld) & ~r_busy[ld_issue_rd_i];
    assign w_ld_fire        = ld_issue_valid_i & ld_issue_ready_o;

    assign w_win_rd   = w_lsu_fire ? lsu_rd_i   : exu_rd_i;
    assign w_win_data = w_lsu_fire ? lsu_data_i : exu_data_i;

    // Scoreboard next state; x0 is never tracked.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_ld_fire) begin
            w_set_mask = 32'h1 << ld_issue_rd_i;
        end
        if (w_lsu_fire) begin
            w_clr_mask = 32'h1 << lsu_rd_i;
        end
        w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'h1;
    end

    // Outstanding-load count: issue adds, return subtracts, both cancel out.
    always_comb begin
        w_cnt_nxt = r_ld_cnt;
        if (w_ld_fire && !w_lsu_fire && (r_ld_cnt != c_max_ld)) begin
            w_cnt_nxt = r_ld_cnt + c_cnt_one;
        end else if (w_lsu_fire && !w_ld_fire && (r_ld_cnt != '0)) begin
            w_cnt_nxt = r_ld_cnt - c_cnt_one;
        end
    end

    // Scoreboard and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= '0;
            r_ld_cnt <= '0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_ld_cnt <= w_cnt_nxt;
        end
    end

    // Writeback stage: reloads every cycle; rd=0 winners produce no write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_vld  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_vld <= (w_lsu_fire | w_exu_fire) & (w_win_rd != 5'd0);
            if (w_lsu_fire | w_exu_fire) begin
                r_wb_addr <= w_win_rd;
                r_wb_data <= w_win_data;
            end
        end
    end

    // A write parked in the stage has not reached the register file yet,
    // so sources matching it must stall as well as sources with loads pending.
    assign w_haz_rs1 = (rs1_addr_i != 5'd0) &
                       (r_busy[rs1_addr_i] | (r_wb_vld & (r_wb_addr == rs1_addr_i)));
    assign w_haz_rs2 = (rs2_addr_i != 5'd0) &
                       (r_busy[rs2_addr_i] | (r_wb_vld & (r_wb_addr == rs2_addr_i)));
    assign w_haz_waw = (id_rd_i != 5'd0) & r_busy[id_rd_i];
    assign hazard_o  = w_haz_rs1 | w_haz_rs2 | w_haz_waw;

    assign rd_wen_o  = r_wb_vld;
    assign rd_addr_o = r_wb_addr;
    assign rd_data_o = r_wb_data;
    assign ld_cnt_o  = r_ld_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040101_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040101_wb_arbiter
// Brief    : Self-checking bench for ysyx_25040101_wb_arbiter: directed
//            scenarios plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040101_wb_arbiter;

    localparam int MAX_LD = 2;
    localparam int CNT_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             exu_valid_i, lsu_valid_i, ld_issue_valid_i;
    logic [4:0]       exu_rd_i, lsu_rd_i, ld_issue_rd_i;
    logic [31:0]      exu_data_i, lsu_data_i;
    logic [4:0]       rs1_addr_i, rs2_addr_i, id_rd_i;
    logic             exu_ready_o, lsu_ready_o, ld_issue_ready_o, hazard_o, rd_wen_o;
    logic [4:0]       rd_addr_o;
    logic [31:0]      rd_data_o;
    logic [CNT_W-1:0] ld_cnt_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          m_busy[32];
    int          m_cnt;
    bit          m_wv;
    int          m_wa;
    logic [31:0] m_wd;
    bit          m_last;
    int          q[$];

    ysyx_25040101_wb_arbiter #(.MAX_LD(MAX_LD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .exu_valid_i(exu_valid_i), .exu_rd_i(exu_rd_i), .exu_data_i(exu_data_i),
        .exu_ready_o(exu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_ready_o(lsu_ready_o),
        .ld_issue_valid_i(ld_issue_valid_i), .ld_issue_rd_i(ld_issue_rd_i),
        .ld_issue_ready_o(ld_issue_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .id_rd_i(id_rd_i),
        .hazard_o(hazard_o),
        .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .ld_cnt_o(ld_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        exu_valid_i = 0; exu_rd_i = 0; exu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        ld_issue_valid_i = 0; ld_issue_rd_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; id_rd_i = 0;
    endtask

    // Leaves the bench at a negedge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    function automatic bit src_blocked(input logic [4:0] r);
        return (r != 0) && (m_busy[r] || (m_wv && m_wa == int'(r)));
    endfunction

    task automatic test_reset();
        do_reset();
        exu_valid_i = 1; exu_rd_i = 5; exu_data_i = 32'h1234;
        ld_issue_valid_i = 1; ld_issue_rd_i = 5;
        @(negedge clk);
        ld_issue_valid_i = 0; exu_rd_i = 6;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        rs1_addr_i = 5; lsu_valid_i = 1; lsu_rd_i = 5;
        #1;
        total++; if (rd_wen_o !== 1'b0) begin bad++; $display("FAIL reset_wen: got %0b want 0", rd_wen_o); end
        total++; if (rd_addr_o !== 5'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr_o); end
        total++; if (rd_data_o !== 32'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", rd_data_o); end
        total++; if (ld_cnt_o !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", ld_cnt_o); end
        total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL reset_hazard: got %0b want 0", hazard_o); end
        total++; if (lsu_ready_o !== 1'b0) begin bad++; $display("FAIL reset_stray_rdy: got %0b want 0", lsu_ready_o); end
    endtask

    task automatic test_exu_only();
        do_reset();
        exu_valid_i = 1; exu_rd_i = 3; exu_data_i = 32'hDEADBEEF;
        #1;
        total++; if (exu_ready_o !== 1'b1) begin bad++; $display("FAIL exu_ready: got %0b want 1", exu_ready_o); end
        @(negedge clk);
        exu_rd_i = 0; exu_data_i = 32'h5555;
        #1;
        total++; if (rd_wen_o !== 1'b1) begin bad++; $display("FAIL exu_wen: got %0b want 1", rd_wen_o); end
        total++; if (rd_addr_o !== 5'd3) begin bad++; $display("FAIL exu_addr: got %0d want 3", rd_addr_o); end
        total++; if (rd_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL exu_data: got %0h want deadbeef", rd_data_o); end
        total++; if (exu_ready_o !== 1'b1) begin bad++; $display("FAIL exu_x0_ready: got %0b want 1", exu_ready_o); end
        @(negedge clk);
        exu_valid_i = 0;
        #1;
        total++; if (rd_wen_o !== 1'b0) begin bad++; $display("FAIL exu_x0_wen: got %0b want 0", rd_wen_o); end
    endtask

    task automatic test_collision();
        do_reset();
        ld_issue_valid_i = 1; ld_issue_rd_i = 7;
        #1;
        total++; if (ld_issue_ready_o !== 1'b1) begin bad++; $display("FAIL col_issue: got %0b want 1", ld_issue_ready_o); end
        @(negedge clk);
        ld_issue_valid_i = 0;
        @(negedge clk);
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h11;
        exu_valid_i = 1; exu_rd_i = 4; exu_data_i = 32'h22;
        #1;
        total++; if (lsu_ready_o !== 1'b1) begin bad++; $display("FAIL col_lsu_rdy: got %0b want 1", lsu_ready_o); end
        total++; if (exu_ready_o !== 1'b0) begin bad++; $display("FAIL col_exu_rdy: got %0b want 0", exu_ready_o); end
        @(negedge clk);
        lsu_valid_i = 0;
        #1;
        total++; if (rd_wen_o !== 1'b1 || rd_addr_o !== 5'd7 || rd_data_o !== 32'h11) begin
            bad++; $display("FAIL col_first: got wen=%0b addr=%0d data=%0h want 1/7/11", rd_wen_o, rd_addr_o, rd_data_o);
        end
        total++; if (exu_ready_o !== 1'b1) begin bad++; $display("FAIL col_exu_retry: got %0b want 1", exu_ready_o); end
        @(negedge clk);
        exu_valid_i = 0;
        #1;
        total++; if (rd_wen_o !== 1'b1 || rd_addr_o !== 5'd4 || rd_data_o !== 32'h22) begin
            bad++; $display("FAIL col_second: got wen=%0b addr=%0d data=%0h want 1/4/22", rd_wen_o, rd_addr_o, rd_data_o);
        end
        total++; if (ld_cnt_o !== 3'd0) begin bad++; $display("FAIL col_cnt: got %0d want 0", ld_cnt_o); end
    endtask

    task automatic test_hazard();
        do_reset();
        ld_issue_valid_i = 1; ld_issue_rd_i = 9;
        @(negedge clk);
        ld_issue_valid_i = 0; rs1_addr_i = 9;
        #1;
        total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL haz_rs1: got %0b want 1", hazard_o); end
        rs1_addr_i = 0; id_rd_i = 9;
        #1;
        total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL haz_waw: got %0b want 1", hazard_o); end
        id_rd_i = 0; rs2_addr_i = 9;
        #1;
        total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL haz_rs2: got %0b want 1", hazard_o); end
        rs2_addr_i = 0; rs1_addr_i = 8;
        #1;
        total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL haz_clean: got %0b want 0", hazard_o); end
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 32'h99;
        @(negedge clk);
        lsu_valid_i = 0; rs1_addr_i = 9;
        #1;
        total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL haz_stage: got %0b want 1", hazard_o); end
        rs1_addr_i = 0; id_rd_i = 9;
        #1;
        total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL haz_waw_clr: got %0b want 0", hazard_o); end
        @(negedge clk);
        id_rd_i = 0; rs1_addr_i = 9;
        #1;
        total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL haz_after: got %0b want 0", hazard_o); end
    endtask

    task automatic test_limit();
        do_reset();
        ld_issue_valid_i = 1; ld_issue_rd_i = 1;
        @(negedge clk);
        ld_issue_rd_i = 2;
        @(negedge clk);
        ld_issue_rd_i = 3;
        #1;
        total++; if (ld_issue_ready_o !== 1'b0) begin bad++; $display("FAIL lim_full: got %0b want 0", ld_issue_ready_o); end
        total++; if (ld_cnt_o !== 3'd2) begin bad++; $display("FAIL lim_cnt2: got %0d want 2", ld_cnt_o); end
        ld_issue_valid_i = 0;
        lsu_valid_i = 1; lsu_rd_i = 2; lsu_data_i = 32'h2;
        @(negedge clk);
        lsu_rd_i = 1; lsu_data_i = 32'h1;
        ld_issue_valid_i = 1; ld_issue_rd_i = 3;
        #1;
        total++; if (ld_issue_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
            bad++; $display("FAIL lim_swap_rdy: got issue=%0b lsu=%0b want 1/1", ld_issue_ready_o, lsu_ready_o);
        end
        @(negedge clk);
        idle_inputs();
        id_rd_i = 1;
        #1;
        total++; if (ld_cnt_o !== 3'd1) begin bad++; $display("FAIL lim_cnt_hold: got %0d want 1", ld_cnt_o); end
        total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL lim_busy1: got %0b want 0", hazard_o); end
        id_rd_i = 3;
        #1;
        total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL lim_busy3: got %0b want 1", hazard_o); end
    endtask

    task automatic test_stray();
        do_reset();
        lsu_valid_i = 1; lsu_rd_i = 6; lsu_data_i = 32'h66;
        #1;
        total++; if (lsu_ready_o !== 1'b0) begin bad++; $display("FAIL stray_rdy: got %0b want 0", lsu_ready_o); end
        @(negedge clk);
        lsu_valid_i = 0;
        #1;
        total++; if (rd_wen_o !== 1'b0) begin bad++; $display("FAIL stray_wen: got %0b want 0", rd_wen_o); end
        total++; if (ld_cnt_o !== 3'd0) begin bad++; $display("FAIL stray_cnt: got %0d want 0", ld_cnt_o); end
    endtask

    task automatic test_random();
        bit lsu_ok, e_lsu, e_exu, e_ld, e_haz;
        do_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_cnt = 0; m_wv = 0; m_wa = 0; m_wd = 0; m_last = 0;
        q.delete();
        for (int i = 0; i < 400; i++) begin
            if (i != 0) @(negedge clk);
            exu_valid_i = 1'($urandom_range(0, 1));
            exu_rd_i    = 5'($urandom_range(0, 7));
            exu_data_i  = $urandom;
            lsu_valid_i = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
            lsu_rd_i    = (q.size() > 0) ? 5'(q[0]) : 5'($urandom_range(0, 7));
            lsu_data_i  = $urandom;
            ld_issue_valid_i = 1'($urandom_range(0, 1));
            ld_issue_rd_i    = 5'($urandom_range(0, 7));
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            id_rd_i    = 5'($urandom_range(0, 7));
            #1;
            lsu_ok = lsu_valid_i && (m_cnt > 0);
`ifdef YSYX_25040101_WB_RR_EN
            if (lsu_ok && exu_valid_i) begin e_lsu = !m_last; e_exu = m_last; end
            else begin e_lsu = lsu_ok; e_exu = exu_valid_i; end
`else
            e_lsu = lsu_ok;
            e_exu = exu_valid_i && !lsu_ok;
`endif
            e_ld  = (m_cnt < MAX_LD) && !m_busy[ld_issue_rd_i];
            e_haz = src_blocked(rs1_addr_i) || src_blocked(rs2_addr_i) ||
                    (id_rd_i != 0 && m_busy[id_rd_i]);
            total++; if (exu_ready_o !== e_exu) begin bad++; $display("FAIL rnd_exu_rdy[%0d]: got %0b want %0b", i, exu_ready_o, e_exu); end
            total++; if (lsu_ready_o !== e_lsu) begin bad++; $display("FAIL rnd_lsu_rdy[%0d]: got %0b want %0b", i, lsu_ready_o, e_lsu); end
            total++; if (ld_issue_ready_o !== e_ld) begin bad++; $display("FAIL rnd_ld_rdy[%0d]: got %0b want %0b", i, ld_issue_ready_o, e_ld); end
            total++; if (hazard_o !== e_haz) begin bad++; $display("FAIL rnd_hazard[%0d]: got %0b want %0b", i, hazard_o, e_haz); end
            total++; if (rd_wen_o !== m_wv) begin bad++; $display("FAIL rnd_wen[%0d]: got %0b want %0b", i, rd_wen_o, m_wv); end
            total++; if (ld_cnt_o !== 3'(m_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, ld_cnt_o, m_cnt); end
            if (m_wv) begin
                total++; if (rd_addr_o !== 5'(m_wa) || rd_data_o !== m_wd) begin
                    bad++; $display("FAIL rnd_write[%0d]: got %0d/%0h want %0d/%0h", i, rd_addr_o, rd_data_o, m_wa, m_wd);
                end
            end
            @(posedge clk);
            if (e_lsu) begin
                m_busy[lsu_rd_i] = 0;
                void'(q.pop_front());
                m_cnt--;
                m_wv = (lsu_rd_i != 0); m_wa = int'(lsu_rd_i); m_wd = lsu_data_i;
                m_last = 1;
            end else if (e_exu) begin
                m_wv = (exu_rd_i != 0); m_wa = int'(exu_rd_i); m_wd = exu_data_i;
                m_last = 0;
            end else begin
                m_wv = 0;
            end
            if (ld_issue_valid_i && e_ld) begin
                if (ld_issue_rd_i != 0) m_busy[ld_issue_rd_i] = 1;
                q.push_back(int'(ld_issue_rd_i));
                m_cnt++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_exu_only();
        test_collision();
        test_hazard();
        test_limit();
        test_stray();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
